multdiv_unit: RTL and testbench

Multicycle signed 32-bit multiply/divide unit for the execute stage of the 5-stage pipeline. Execute issues a start pulse with both operands; the unit iterates internally, asserts `busy` so hazard logic can stall fetch/decode/execute, and emits a one-cycle ready pulse with the result. The result goes into the execute/memory O latch. Multiply uses radix-4 modified Booth; divide uses radix-2 non-restoring.

---
 rtl/multdiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiplier (radix-4 Booth) and divider (radix-2 non-restoring).
// Define MULTDIV_DIV_EN to build the divide datapath; without it a divide returns 0 with the exception flag set.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [5:0] MULT_LAST = 6'd16;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [64:0] booth_q, booth_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    // Booth step: {product, multiplier, guard} with a 34-bit sign-extended add, then >>> 2
    logic [33:0] m1_ext, m2_ext, acc_ext, pp, booth_sum;
    logic [64:0] booth_next;
    logic        mult_ovf;

    always_comb begin
        m1_ext  = {{2{mcand_q[31]}}, mcand_q};
        m2_ext  = {mcand_q[31], mcand_q, 1'b0};
        acc_ext = {{2{booth_q[64]}}, booth_q[64:33]};
        case (booth_q[2:0])
            3'b001, 3'b010: pp = m1_ext;
            3'b011:         pp = m2_ext;
            3'b100:         pp = -m2_ext;
            3'b101, 3'b110: pp = -m1_ext;
            default:        pp = '0;
        endcase
        booth_sum  = acc_ext + pp;
        booth_next = {booth_sum, booth_q[32:2]};
        // product bits [63:31] sit at booth_q[64:32]; they must all match the sign
        mult_ovf   = !((&booth_q[64:32]) || !(|booth_q[64:32]));
    end

`ifdef MULTDIV_DIV_EN
    localparam logic [5:0] DIV_FIX  = 6'd32;
    localparam logic [5:0] DIV_LAST = 6'd33;

    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic        neg_q, neg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;

    logic [31:0] a_mag, b_mag;
    logic [32:0] dvsr_ext, rem_shl, rem_next;

    always_comb begin
        a_mag    = data_operandA[31] ? -data_operandA : data_operandA;
        b_mag    = data_operandB[31] ? -data_operandB : data_operandB;
        dvsr_ext = {1'b0, dvsr_q};
        rem_shl  = {rem_q[31:0], quo_q[31]};
        rem_next = rem_q[32] ? (rem_shl + dvsr_ext) : (rem_shl - dvsr_ext);
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        booth_d = booth_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_DIV_EN
        dvsr_d  = dvsr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        neg_d   = neg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
`endif
        // A start in any state (including mid-operation) discards the current work
        if (ctrl_MULT) begin
            state_d = S_MULT;
            cnt_d   = '0;
            mcand_d = data_operandA;
            booth_d = {32'd0, data_operandB, 1'b0};
        end else if (ctrl_DIV) begin
            state_d = S_DIV;
            cnt_d   = '0;
`ifdef MULTDIV_DIV_EN
            dvsr_d  = b_mag;
            quo_d   = a_mag;
            rem_d   = '0;
            neg_d   = data_operandA[31] ^ data_operandB[31];
            dz_d    = (data_operandB == 32'd0);
            ovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
`endif
        end else begin
            case (state_q)
                S_MULT: begin
                    if (cnt_q == MULT_LAST) begin
                        state_d = S_DONE;
                        res_d   = booth_q[32:1];
                        exc_d   = mult_ovf;
                    end else begin
                        booth_d = booth_next;
                        cnt_d   = cnt_q + 6'd1;
                    end
                end
                S_DIV: begin
`ifdef MULTDIV_DIV_EN
                    if (cnt_q == DIV_LAST) begin
                        state_d = S_DONE;
                        res_d   = dz_q ? 32'd0 : quo_q;
                        exc_d   = dz_q | ovf_q;
                    end else if (cnt_q == DIV_FIX) begin
                        if (rem_q[32]) begin
                            rem_d = rem_q + dvsr_ext;
                        end
                        quo_d = neg_q ? -quo_q : quo_q;
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        rem_d = rem_next;
                        quo_d = {quo_q[30:0], ~rem_next[32]};
                        cnt_d = cnt_q + 6'd1;
                    end
`else
                    state_d = S_DONE;
                    res_d   = 32'd0;
                    exc_d   = 1'b1;
`endif
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            booth_q <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            booth_q <= booth_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

`ifdef MULTDIV_DIV_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dvsr_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            dvsr_q <= dvsr_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            neg_q  <= neg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy = (state_q == S_MULT) || (state_q == S_DIV);
`else
    assign busy = (state_q == S_MULT);
`endif

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit; follows MULTDIV_DIV_EN to pick the divide expectations.
module tb_multdiv_unit;

    logic        clk;
    logic        rst;
    logic [31:0] opa, opb;
    logic        cmul, cdiv;
    logic [31:0] res;
    logic        exc, rdy, busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT_MULT = 17;
`ifdef MULTDIV_DIV_EN
    localparam int LAT_DIV  = 34;
    localparam int BUSY_DIV = 34;
    localparam bit DIV_ON   = 1'b1;
`else
    localparam int LAT_DIV  = 1;
    localparam int BUSY_DIV = 0;
    localparam bit DIV_ON   = 1'b0;
`endif
    localparam longint LIM = 64'sd2147483648;

    multdiv_unit dut (
        .clock          (clk),
        .reset          (rst),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (cmul),
        .ctrl_DIV       (cdiv),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic and SV signed division
    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e,
                                  output int lat, output int nb);
        longint p;
        if (m) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            r   = p[31:0];
            e   = (p >= LIM) || (p < -LIM);
            lat = LAT_MULT;
            nb  = LAT_MULT;
        end else begin
            lat = LAT_DIV;
            nb  = BUSY_DIV;
            if (!DIV_ON || b == 32'd0) begin
                r = 32'd0;
                e = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r = 32'h8000_0000;
                e = 1'b1;
            end else begin
                r = $signed(a) / $signed(b);
                e = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0: begin v = $urandom_range(0, 20); v = v - 32'd10; end
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd0;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issues one start, then observes 46 sample points (E0+1 .. E45+1); inputs scrambled after E0
    task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy, output int nrdy,
                         output logic [31:0] r, output logic e);
        lat = -1; nbusy = 0; nrdy = 0; r = 32'hDEAD_BEEF; e = 1'bx;
        @(negedge clk);
        cmul = m; cdiv = d; opa = a; opb = b;
        for (int k = 0; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                cmul = 1'b0; cdiv = 1'b0; opa = $urandom; opb = $urandom;
            end
            if (busy) nbusy++;
            if (rdy) begin
                nrdy++;
                if (lat < 0) begin
                    lat = k; r = res; e = exc;
                end
            end
        end
    endtask

    task automatic test_reset();
        cmul = 0; cdiv = 0; opa = 0; opb = 0; rst = 0;
        #2 rst = 1;
        #3;
        n_tests += 4;
        if (res !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", res); end
        if (exc !== 1'b0)  begin n_fail++; $display("FAIL reset_exc: got %b want 0", exc); end
        if (rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_mult_directed();
        logic [31:0] va [3] = '{32'd7, 32'h0001_0000, 32'h8000_0000};
        logic [31:0] vb [3] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'd1};
        logic [31:0] vr [3] = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h8000_0000};
        logic        ve [3] = '{1'b0, 1'b1, 1'b0};
        int lat, nb, nr; logic [31:0] r; logic e;
        for (int i = 0; i < 3; i++) begin
            do_op(1, 0, va[i], vb[i], lat, nb, nr, r, e);
            n_tests += 5;
            if (r !== vr[i]) begin n_fail++; $display("FAIL mult_dir%0d_result: got %h want %h", i, r, vr[i]); end
            if (e !== ve[i]) begin n_fail++; $display("FAIL mult_dir%0d_exc: got %b want %b", i, e, ve[i]); end
            if (lat != 17)   begin n_fail++; $display("FAIL mult_dir%0d_latency: got %0d want 17", i, lat); end
            if (nb != 17)    begin n_fail++; $display("FAIL mult_dir%0d_busy_cycles: got %0d want 17", i, nb); end
            if (nr != 1)     begin n_fail++; $display("FAIL mult_dir%0d_rdy_pulses: got %0d want 1", i, nr); end
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] va [4] = '{32'hFFFF_FF9C, 32'h8000_0000, 32'd5, 32'd100};
        logic [31:0] vb [4] = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'd5};
`ifdef MULTDIV_DIV_EN
        logic [31:0] vr [4] = '{32'hFFFF_FFF2, 32'h8000_0000, 32'd0, 32'd20};
        logic        ve [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`else
        logic [31:0] vr [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
        logic        ve [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        int lat, nb, nr; logic [31:0] r; logic e;
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1, va[i], vb[i], lat, nb, nr, r, e);
            n_tests += 5;
            if (r !== vr[i])    begin n_fail++; $display("FAIL div_dir%0d_result: got %h want %h", i, r, vr[i]); end
            if (e !== ve[i])    begin n_fail++; $display("FAIL div_dir%0d_exc: got %b want %b", i, e, ve[i]); end
            if (lat != LAT_DIV) begin n_fail++; $display("FAIL div_dir%0d_latency: got %0d want %0d", i, lat, LAT_DIV); end
            if (nb != BUSY_DIV) begin n_fail++; $display("FAIL div_dir%0d_busy_cycles: got %0d want %0d", i, nb, BUSY_DIV); end
            if (nr != 1)        begin n_fail++; $display("FAIL div_dir%0d_rdy_pulses: got %0d want 1", i, nr); end
        end
    endtask

    task automatic test_random();
        int lat, nb, nr, elat, enb; logic [31:0] r, er, a, b; logic e, ee; bit m, d;
        for (int i = 0; i < 60; i++) begin
            m = $urandom_range(0, 1);
            d = m ? $urandom_range(0, 1) : 1'b1;
            a = rnd_op(); b = rnd_op();
            model(m, a, b, er, ee, elat, enb);
            do_op(m, d, a, b, lat, nb, nr, r, e);
            n_tests += 5;
            if (r !== er)   begin n_fail++; $display("FAIL rand%0d_result (m=%0d %h,%h): got %h want %h", i, m, a, b, r, er); end
            if (e !== ee)   begin n_fail++; $display("FAIL rand%0d_exc (m=%0d %h,%h): got %b want %b", i, m, a, b, e, ee); end
            if (lat != elat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, elat); end
            if (nb != enb)  begin n_fail++; $display("FAIL rand%0d_busy_cycles: got %0d want %0d", i, nb, enb); end
            if (nr != 1)    begin n_fail++; $display("FAIL rand%0d_rdy_pulses: got %0d want 1", i, nr); end
        end
    endtask

    task automatic test_simultaneous();
        int lat, nb, nr; logic [31:0] r; logic e;
        do_op(1, 1, 32'd6, 32'd3, lat, nb, nr, r, e);
        n_tests += 3;
        if (r !== 32'h12) begin n_fail++; $display("FAIL simul_result: got %h want 00000012", r); end
        if (e !== 1'b0)   begin n_fail++; $display("FAIL simul_exc: got %b want 0", e); end
        if (lat != 17)    begin n_fail++; $display("FAIL simul_latency: got %0d want 17", lat); end
    endtask

    task automatic test_restart();
        int nr, last; logic [31:0] r;
        nr = 0; last = -1; r = 32'hDEAD_BEEF;
        @(negedge clk);
        cdiv = 1; opa = 32'd100; opb = 32'd5;
        @(posedge clk); #1;
        cdiv = 0; opa = $urandom; opb = $urandom;
        for (int k = 1; k <= 50; k++) begin
            if (k == 10) begin cmul = 1; opa = 32'd3; opb = 32'd4; end
            @(posedge clk); #1;
            if (k == 10) begin cmul = 0; opa = $urandom; opb = $urandom; end
            if (rdy) begin nr++; last = k; r = res; end
        end
        n_tests += 3;
        if (nr != (DIV_ON ? 1 : 2)) begin n_fail++; $display("FAIL restart_rdy_pulses: got %0d want %0d", nr, DIV_ON ? 1 : 2); end
        if (last != 27)             begin n_fail++; $display("FAIL restart_rdy_edge: got %0d want 27", last); end
        if (r !== 32'h0000_000C)    begin n_fail++; $display("FAIL restart_result: got %h want 0000000c", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, er1, er2, r1, r2; logic ee1, ee2, e1, e2;
        int el, enb, k1, k2, nr; logic busy17, busy18;
        a1 = rnd_op(); b1 = rnd_op(); a2 = rnd_op(); b2 = rnd_op();
        model(1, a1, b1, er1, ee1, el, enb);
        model(1, a2, b2, er2, ee2, el, enb);
        k1 = -1; k2 = -1; nr = 0; r1 = 0; r2 = 0; e1 = 0; e2 = 0; busy17 = 1'bx; busy18 = 1'bx;
        @(negedge clk);
        cmul = 1; opa = a1; opb = b1;
        @(posedge clk); #1;
        cmul = 0; opa = $urandom; opb = $urandom;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (k == 18) begin cmul = 0; opa = $urandom; opb = $urandom; busy18 = busy; end
            if (k == 17) busy17 = busy;
            if (rdy) begin
                nr++;
                if (k1 < 0) begin k1 = k; r1 = res; e1 = exc; end
                else begin k2 = k; r2 = res; e2 = exc; end
            end
            if (k == 17) begin cmul = 1; opa = a2; opb = b2; end
        end
        n_tests += 9;
        if (k1 != 17)       begin n_fail++; $display("FAIL b2b_first_edge: got %0d want 17", k1); end
        if (k2 != 35)       begin n_fail++; $display("FAIL b2b_second_edge: got %0d want 35", k2); end
        if (nr != 2)        begin n_fail++; $display("FAIL b2b_rdy_pulses: got %0d want 2", nr); end
        if (r1 !== er1)     begin n_fail++; $display("FAIL b2b_first_result: got %h want %h", r1, er1); end
        if (e1 !== ee1)     begin n_fail++; $display("FAIL b2b_first_exc: got %b want %b", e1, ee1); end
        if (r2 !== er2)     begin n_fail++; $display("FAIL b2b_second_result: got %h want %h", r2, er2); end
        if (e2 !== ee2)     begin n_fail++; $display("FAIL b2b_second_exc: got %b want %b", e2, ee2); end
        if (busy17 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_rdy: got %b want 0", busy17); end
        if (busy18 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_after_restart: got %b want 1", busy18); end
    endtask

    task automatic test_reset_mid();
        int lat, nb, nr; logic [31:0] r; logic e;
        do_op(1, 0, 32'd7, 32'hFFFF_FFFA, lat, nb, nr, r, e);
        @(negedge clk);
        cmul = 1; opa = $urandom; opb = $urandom;
        @(posedge clk); #1;
        cmul = 0;
        repeat (8) @(posedge clk);
        #1 rst = 1;
        #1;
        n_tests += 5;
        if (res !== 32'd0) begin n_fail++; $display("FAIL midreset_result: got %h want 00000000", res); end
        if (exc !== 1'b0)  begin n_fail++; $display("FAIL midreset_exc: got %b want 0", exc); end
        if (rdy !== 1'b0)  begin n_fail++; $display("FAIL midreset_rdy: got %b want 0", rdy); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 0;
        nr = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (rdy || busy) nr++;
        end
        if (nr != 0) begin n_fail++; $display("FAIL midreset_activity_after_release: got %0d cycles want 0", nr); end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_simultaneous();
        test_restart();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
